// File: rtl/status_seq.sv
// Processor status register sequencer: one flag operation per start pulse,
// one-hot write/output strobes, branch evaluation and IRQ entry (push, then SEI).
module status_seq #(
    parameter int WAIT_MAX = 15,
    parameter int CW       = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [3:0] i_op,
    input  logic [2:0] i_cond,
    input  logic [7:0] i_status,
    input  logic       i_alu_valid,
    input  logic       i_bus_rdy,
    input  logic       i_irq,
    output logic       o_wair,
    output logic       o_waalu,
    output logic       o_wabus,
    output logic       o_oa,
    output logic       o_ircary,
    output logic       o_irirqdis,
    output logic       o_irdecmode,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_taken,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_ALUWAIT, S_PUSH, S_PULLWAIT, S_IRQSEI
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_irq_push;
    logic          r_wr;
    logic          r_set_c, r_set_i, r_set_d;
    logic          r_val_c, r_val_i, r_val_d;
    logic          r_taken;

    logic w_tmo, w_flag;
    logic w_alu_hit, w_alu_tmo, w_push_hit, w_push_tmo, w_pull_hit, w_pull_tmo;
    logic w_tmo_any, w_exec, w_sei;
    logic w_unused;

    // Bits 5:4 of the status byte carry no flag this block cares about.
    assign w_unused = &{1'b0, i_status[5:4]};

    assign w_tmo  = (r_cnt == CW'(WAIT_MAX));
    assign w_flag = (i_cond[2:1] == 2'd0) ? i_status[0] :
                    (i_cond[2:1] == 2'd1) ? i_status[1] :
                    (i_cond[2:1] == 2'd2) ? i_status[6] : i_status[7];

    assign w_exec     = (r_state == S_EXEC);
    assign w_sei      = (r_state == S_IRQSEI);
    assign w_alu_hit  = (r_state == S_ALUWAIT)  &&  i_alu_valid;
    assign w_alu_tmo  = (r_state == S_ALUWAIT)  && !i_alu_valid && w_tmo;
    assign w_push_hit = (r_state == S_PUSH)     &&  i_bus_rdy;
    assign w_push_tmo = (r_state == S_PUSH)     && !i_bus_rdy   && w_tmo;
    assign w_pull_hit = (r_state == S_PULLWAIT) &&  i_bus_rdy;
    assign w_pull_tmo = (r_state == S_PULLWAIT) && !i_bus_rdy   && w_tmo;
    assign w_tmo_any  = w_alu_tmo || w_push_tmo || w_pull_tmo;

    // Handshake strobes follow the handshake in the same cycle, so every
    // output is forced low while reset is asserted.
    always_comb begin
        o_wair      = !i_reset && ((w_exec && r_wr) || w_sei);
        o_waalu     = !i_reset && w_alu_hit;
        o_wabus     = !i_reset && w_pull_hit;
        o_oa        = !i_reset && (r_state == S_PUSH) && !w_push_tmo;
        o_busy      = !i_reset && (r_state != S_IDLE);
        o_done      = !i_reset && (w_exec || w_sei || w_alu_hit || w_pull_hit ||
                                   (w_push_hit && !r_irq_push) || w_tmo_any);
        o_err       = !i_reset && w_tmo_any;
        o_taken     = !i_reset && r_taken;
        o_ircary    = !i_reset && ((w_exec && r_set_c) ? r_val_c : i_status[0]);
        o_irirqdis  = !i_reset && (w_sei || ((w_exec && r_set_i) ? r_val_i : i_status[2]));
        o_irdecmode = !i_reset && ((w_exec && r_set_d) ? r_val_d : i_status[3]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_irq_push <= 1'b0;
            r_wr       <= 1'b0;
            r_set_c    <= 1'b0;
            r_set_i    <= 1'b0;
            r_set_d    <= 1'b0;
            r_val_c    <= 1'b0;
            r_val_i    <= 1'b0;
            r_val_d    <= 1'b0;
            r_taken    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state    <= S_EXEC;
                    r_cnt      <= '0;
                    r_irq_push <= 1'b0;
                    r_wr       <= 1'b0;
                    r_set_c    <= 1'b0;
                    r_set_i    <= 1'b0;
                    r_set_d    <= 1'b0;
                    r_taken    <= 1'b0;
                    case (i_op)
                        4'd1, 4'd2: begin r_wr <= 1'b1; r_set_c <= 1'b1; r_val_c <= (i_op == 4'd2); end
                        4'd3, 4'd4: begin r_wr <= 1'b1; r_set_i <= 1'b1; r_val_i <= (i_op == 4'd4); end
                        4'd5, 4'd6: begin r_wr <= 1'b1; r_set_d <= 1'b1; r_val_d <= (i_op == 4'd6); end
                        4'd7:  r_state <= S_ALUWAIT;
                        4'd8:  r_state <= S_PUSH;
                        4'd9:  r_state <= S_PULLWAIT;
                        4'd10: r_taken <= (w_flag == i_cond[0]);
                        4'd11: if (i_irq && !i_status[2]) begin
                            r_state    <= S_PUSH;
                            r_irq_push <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EXEC, S_IRQSEI: r_state <= S_IDLE;
                S_ALUWAIT:
                    if (i_alu_valid || w_tmo) r_state <= S_IDLE;
                    else                      r_cnt   <= r_cnt + 1'b1;
                S_PULLWAIT:
                    if (i_bus_rdy || w_tmo) r_state <= S_IDLE;
                    else                    r_cnt   <= r_cnt + 1'b1;
                S_PUSH:
                    // A timed-out IRQ push abandons entry without setting I.
                    if (i_bus_rdy) r_state <= r_irq_push ? S_IRQSEI : S_IDLE;
                    else if (w_tmo) r_state <= S_IDLE;
                    else            r_cnt   <= r_cnt + 1'b1;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_status_seq.sv
// Directed bench for status_seq; output vector order:
// {wair,waalu,wabus,oa, busy,done,err, taken, ircary,irirqdis,irdecmode}
module tb_status_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0;
    logic [3:0] op = '0;
    logic [2:0] cond = '0;
    logic [7:0] status = '0;
    logic       alu_valid = 1'b0, bus_rdy = 1'b0, irq = 1'b0;
    logic       wair, waalu, wabus, oa, ircary, irirqdis, irdecmode;
    logic       busy, done, taken, err;

    int checks = 0;
    int errors = 0;

    status_seq #(.WAIT_MAX(15), .CW(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op), .i_cond(cond),
        .i_status(status), .i_alu_valid(alu_valid), .i_bus_rdy(bus_rdy), .i_irq(irq),
        .o_wair(wair), .o_waalu(waalu), .o_wabus(wabus), .o_oa(oa),
        .o_ircary(ircary), .o_irirqdis(irirqdis), .o_irdecmode(irdecmode),
        .o_busy(busy), .o_done(done), .o_taken(taken), .o_err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ov();
        return {wair, waalu, wabus, oa, busy, done, err, taken, ircary, irirqdis, irdecmode};
    endfunction

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] exp);
        #1;
        checks++;
        assert (ov() === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, ov(), exp);
        end
    endtask

    logic [7:0] bst [5] = '{8'h02, 8'h40, 8'h40, 8'h80, 8'hFE};
    logic [2:0] bcd [5] = '{3'b011, 3'b100, 3'b101, 3'b111, 3'b001};
    logic       btk [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        go(); go();
        reset = 1'b0;
        chk("reset", 11'b0000_000_0_000);

        // CLC with status C3: only C overridden
        status = 8'hC3; start = 1'b1; op = 4'd1;
        chk("idle_c3", 11'b0000_000_0_100);
        go(); start = 1'b0;
        chk("clc", 11'b1000_110_0_000);
        go(); chk("clc_idle", 11'b0000_000_0_100);

        // SEI with D preserved
        status = 8'h08; start = 1'b1; op = 4'd4;
        go(); start = 1'b0;
        chk("sei", 11'b1000_110_0_011);
        go(); chk("sei_idle", 11'b0000_000_0_001);

        // ALU, alu_valid in third cycle; a start while busy is ignored
        status = 8'h00; start = 1'b1; op = 4'd7;
        go(); op = 4'd1;
        chk("alu_w1", 11'b0000_100_0_000);
        go(); start = 1'b0;
        chk("alu_w2", 11'b0000_100_0_000);
        go(); alu_valid = 1'b1;
        chk("alu_hit", 11'b0100_110_0_000);
        go(); alu_valid = 1'b0;
        chk("alu_idle", 11'b0000_000_0_000);

        // ALU timeout: 15 waiting cycles then done+err
        start = 1'b1; op = 4'd7;
        go(); start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) go();
            chk($sformatf("alu_wait%0d", k), 11'b0000_100_0_000);
        end
        go(); chk("alu_tmo", 11'b0000_111_0_000);
        go(); chk("alu_tmo_idle", 11'b0000_000_0_000);

        // Branch conditions, taken held after done
        for (int i = 0; i < 5; i++) begin
            status = bst[i]; cond = bcd[i]; op = 4'd10; start = 1'b1;
            go(); start = 1'b0;
            chk($sformatf("br%0d", i), {7'b0000_110, btk[i], bst[i][0], bst[i][2], bst[i][3]});
            go();
            chk($sformatf("br%0d_hold", i), {7'b0000_000, btk[i], bst[i][0], bst[i][2], bst[i][3]});
        end

        // IRQ entry with immediate bus_rdy
        status = 8'h00; irq = 1'b1; op = 4'd11; start = 1'b1;
        go(); start = 1'b0; bus_rdy = 1'b1;
        chk("irq_push", 11'b0001_100_0_000);
        go(); bus_rdy = 1'b0;
        chk("irq_sei", 11'b1000_110_0_010);
        go(); chk("irq_idle", 11'b0000_000_0_000);

        // IRQ masked by I
        status = 8'h04; start = 1'b1;
        go(); start = 1'b0;
        chk("irq_masked", 11'b0000_110_0_010);
        go(); chk("irq_masked_idle", 11'b0000_000_0_010);

        // IRQ op with irq low
        status = 8'h00; irq = 1'b0; start = 1'b1;
        go(); start = 1'b0;
        chk("irq_none", 11'b0000_110_0_000);

        // IRQ push timeout skips the SEI cycle
        go(); irq = 1'b1; start = 1'b1;
        go(); start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) go();
            chk($sformatf("irq_wait%0d", k), 11'b0001_100_0_000);
        end
        go(); chk("irq_tmo", 11'b0000_111_0_000);
        go(); irq = 1'b0;
        chk("irq_tmo_idle", 11'b0000_000_0_000);

        // PHP with bus_rdy in the second cycle
        op = 4'd8; start = 1'b1;
        go(); start = 1'b0;
        chk("php_w1", 11'b0001_100_0_000);
        go(); bus_rdy = 1'b1;
        chk("php_done", 11'b0001_110_0_000);
        go(); bus_rdy = 1'b0;

        // PLP with immediate bus_rdy
        op = 4'd9; start = 1'b1;
        go(); start = 1'b0; bus_rdy = 1'b1;
        chk("plp", 11'b0010_110_0_000);
        go(); bus_rdy = 1'b0;
        chk("plp_idle", 11'b0000_000_0_000);

        // Reset while PLP waits; no strobe in reset cycle or after
        op = 4'd9; start = 1'b1;
        go(); start = 1'b0;
        chk("plp_wait", 11'b0000_100_0_000);
        go(); reset = 1'b1; bus_rdy = 1'b1;
        chk("rst_cycle", 11'b0000_000_0_000);
        go(); reset = 1'b0;
        chk("rst_after", 11'b0000_000_0_000);
        bus_rdy = 1'b0; op = 4'd2; start = 1'b1;
        go(); start = 1'b0;
        chk("sec_after_rst", 11'b1000_110_0_100);
        go(); chk("sec_idle", 11'b0000_000_0_000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
